// File: rtl/upload_arbiter_nch_if.sv
// Bundles the per-source upload inputs and the merged processor-side stream.
// slave = arbiter view, master = the sources/processor driving and consuming it.
interface upload_arbiter_nch_if #(
  parameter int N = 4
);
  logic [8*N-1:0] src_upload_data;
  logic [8*N-1:0] src_upload_source;
  logic [N-1:0]   src_upload_last;
  logic [N-1:0]   src_upload_valid;
  logic [N-1:0]   src_upload_ready;
  logic [N-1:0]   src_overflow;
  logic           merged_upload_req;
  logic [7:0]     merged_upload_data;
  logic [7:0]     merged_upload_source;
  logic           merged_upload_last;
  logic [2:0]     merged_upload_chan;
  logic           merged_upload_valid;
  logic           processor_upload_ready;

  modport slave (
    input  src_upload_data, src_upload_source, src_upload_last, src_upload_valid,
    input  processor_upload_ready,
    output src_upload_ready, src_overflow,
    output merged_upload_req, merged_upload_data, merged_upload_source,
    output merged_upload_last, merged_upload_chan, merged_upload_valid
  );

  modport master (
    output src_upload_data, src_upload_source, src_upload_last, src_upload_valid,
    output processor_upload_ready,
    input  src_upload_ready, src_overflow,
    input  merged_upload_req, merged_upload_data, merged_upload_source,
    input  merged_upload_last, merged_upload_chan, merged_upload_valid
  );
endinterface

// File: rtl/upload_arbiter_nch.sv
// N-channel packet-aware upload arbiter: one FIFO per source, packets never interleave,
// fixed-priority or round-robin grant between packets, 1 byte/clk streaming.

// Per-source FIFO; entry = {data, source, last}. Head is read combinationally.
module upload_arbiter_nch_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         nempty_o,
  output logic         ready_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q;
  logic          wr_en, rd_en;

  assign ready_o    = (cnt_q != (AW+1)'(DEPTH));
  assign nempty_o   = (cnt_q != '0);
  assign wr_en      = wr_valid_i && ready_o;
  assign rd_en      = rd_en_i && nempty_o;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign overflow_o = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      // Sticky until reset: any byte offered while full is lost.
      if (wr_valid_i && !ready_o) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

module upload_arbiter_nch #(
  parameter int NUM_SOURCES = 4,
  parameter int FIFO_DEPTH  = 64,
  parameter int ARB_MODE    = 1
) (
  input logic                 clk,
  input logic                 rst,
  upload_arbiter_nch_if.slave bus
);
  localparam int CH_W  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int ENT_W = 17;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                                 state_q;
  logic [NUM_SOURCES-1:0]                 ne, pop, rdy, ovf;
  logic [NUM_SOURCES-1:0][ENT_W-1:0]      head;
  logic [CH_W-1:0]                        gsel, chan_q, rr_q, rr_d, cur_sel;
  logic                                   any_ne, stream_pop;
  logic                                   req_q, valid_q, last_q;
  logic [7:0]                             data_q, src_q;
  logic [ENT_W-1:0]                       pop_ent;
  int                                     idx;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    upload_arbiter_nch_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_valid_i (bus.src_upload_valid[i]),
      .wr_data_i  ({bus.src_upload_data[i*8+:8], bus.src_upload_source[i*8+:8],
                    bus.src_upload_last[i]}),
      .rd_en_i    (pop[i]),
      .rd_data_o  (head[i]),
      .nempty_o   (ne[i]),
      .ready_o    (rdy[i]),
      .overflow_o (ovf[i])
    );
  end

  assign bus.src_upload_ready = rdy;
  assign bus.src_overflow     = ovf;

  // Scan starts at rr_q in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    gsel   = '0;
    any_ne = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = (ARB_MODE == 1) ? int'(rr_q) + k : k;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (!any_ne && ne[idx]) begin
        any_ne = 1'b1;
        gsel   = CH_W'(idx);
      end
    end
  end

  // In STREAM, refill the output register when it is empty or being consumed mid-packet.
  assign stream_pop = (state_q == STREAM) && ne[chan_q] &&
                      (!valid_q || (bus.processor_upload_ready && !last_q));
  assign cur_sel    = (state_q == IDLE) ? gsel : chan_q;
  assign pop_ent    = head[cur_sel];
  assign rr_d       = (chan_q == CH_W'(NUM_SOURCES-1)) ? '0 : chan_q + 1'b1;

  always_comb begin
    pop = '0;
    if (state_q == IDLE && any_ne) pop[gsel]   = 1'b1;
    else if (stream_pop)           pop[chan_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_ne) begin
            {data_q, src_q, last_q} <= pop_ent;
            valid_q <= 1'b1;
            req_q   <= 1'b1;
            chan_q  <= gsel;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (stream_pop) begin
            {data_q, src_q, last_q} <= pop_ent;
            valid_q <= 1'b1;
          end else if (valid_q && bus.processor_upload_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              req_q   <= 1'b0;
              rr_q    <= rr_d;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.merged_upload_req    = req_q;
  assign bus.merged_upload_valid  = valid_q;
  assign bus.merged_upload_data   = data_q;
  assign bus.merged_upload_source = src_q;
  assign bus.merged_upload_last   = last_q;
  assign bus.merged_upload_chan   = 3'(chan_q);
endmodule

// File: tb/tb_upload_arbiter_nch.sv
// Scoreboard bench: dut_a is round-robin, dut_b fixed priority, both with 4-deep FIFOs.
module tb_upload_arbiter_nch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  upload_arbiter_nch_if #(.N(4)) ifa ();
  upload_arbiter_nch_if #(.N(4)) ifb ();

  upload_arbiter_nch #(.NUM_SOURCES(4), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  upload_arbiter_nch #(.NUM_SOURCES(4), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
    logic [7:0] s;
    logic       l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic sb(input int w, input exp_t act);
    exp_t e;
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL sb%0d unexpected byte got=%h want=none", w, act);
    end else begin
      if (w == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      chk(w == 0 ? "sbA" : "sbB", 32'(act), 32'(e));
    end
  endtask

  // Monitor: a byte is transferred at the next posedge when valid && ready here.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.merged_upload_valid && ifa.processor_upload_ready)
        sb(0, {ifa.merged_upload_chan, ifa.merged_upload_data,
               ifa.merged_upload_source, ifa.merged_upload_last});
      if (ifb.merged_upload_valid && ifb.processor_upload_ready)
        sb(1, {ifb.merged_upload_chan, ifb.merged_upload_data,
               ifb.merged_upload_source, ifb.merged_upload_last});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int s, input logic [7:0] d, input logic [7:0] t, input logic l);
    ifa.src_upload_data[s*8+:8]   = d;
    ifa.src_upload_source[s*8+:8] = t;
    ifa.src_upload_last[s]        = l;
    ifa.src_upload_valid[s]       = 1'b1;
    tick();
    ifa.src_upload_valid[s] = 1'b0;
    ifa.src_upload_last[s]  = 1'b0;
  endtask

  task automatic wr_b(input int s, input logic [7:0] d, input logic [7:0] t, input logic l);
    ifb.src_upload_data[s*8+:8]   = d;
    ifb.src_upload_source[s*8+:8] = t;
    ifb.src_upload_last[s]        = l;
    ifb.src_upload_valid[s]       = 1'b1;
    tick();
    ifb.src_upload_valid[s] = 1'b0;
    ifb.src_upload_last[s]  = 1'b0;
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (((w == 0) ? qa.size() : qb.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(w == 0 ? "drainA" : "drainB", (w == 0) ? qa.size() : qb.size(), 0);
    repeat (3) tick();
  endtask

  task automatic chk_idle_a(input string nm);
    chk({nm, "_req"},   ifa.merged_upload_req,    0);
    chk({nm, "_valid"}, ifa.merged_upload_valid,  0);
    chk({nm, "_data"},  ifa.merged_upload_data,   0);
    chk({nm, "_src"},   ifa.merged_upload_source, 0);
    chk({nm, "_last"},  ifa.merged_upload_last,   0);
    chk({nm, "_chan"},  ifa.merged_upload_chan,   0);
    chk({nm, "_ovf"},   ifa.src_overflow,         0);
    chk({nm, "_rdy"},   ifa.src_upload_ready,     4'hf);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.src_upload_data = '0; ifa.src_upload_source = '0;
    ifa.src_upload_last = '0; ifa.src_upload_valid  = '0;
    ifa.processor_upload_ready = 1'b1;
    ifb.src_upload_data = '0; ifb.src_upload_source = '0;
    ifb.src_upload_last = '0; ifb.src_upload_valid  = '0;
    ifb.processor_upload_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk_idle_a("rstA");
    chk("rstB_req",   ifb.merged_upload_req,   0);
    chk("rstB_valid", ifb.merged_upload_valid, 0);
    chk("rstB_rdy",   ifb.src_upload_ready,    4'hf);
    tick();

    // 1: three-byte packet on src1, one byte per clk
    qa.push_back('{3'd1, 8'hA1, 8'h51, 1'b0});
    qa.push_back('{3'd1, 8'hA2, 8'h51, 1'b0});
    qa.push_back('{3'd1, 8'hA3, 8'h51, 1'b1});
    wr_a(1, 8'hA1, 8'h51, 1'b0);
    wr_a(1, 8'hA2, 8'h51, 1'b0);
    wr_a(1, 8'hA3, 8'h51, 1'b1);
    @(negedge clk);
    chk("t1_b2", {ifa.merged_upload_valid, ifa.merged_upload_chan, ifa.merged_upload_data,
                  ifa.merged_upload_last}, {1'b1, 3'd1, 8'hA2, 1'b0});
    @(negedge clk);
    chk("t1_b3", {ifa.merged_upload_valid, ifa.merged_upload_req, ifa.merged_upload_data,
                  ifa.merged_upload_last}, {1'b1, 1'b1, 8'hA3, 1'b1});
    @(negedge clk);
    chk("t1_end", {ifa.merged_upload_req, ifa.merged_upload_valid}, 2'b00);
    tick();
    drain(0);

    // 2: fixed priority, src2 mid-packet is not preempted by src0
    qb.push_back('{3'd2, 8'hC1, 8'h82, 1'b0});
    qb.push_back('{3'd2, 8'hC2, 8'h82, 1'b0});
    qb.push_back('{3'd2, 8'hC3, 8'h82, 1'b1});
    qb.push_back('{3'd0, 8'hD1, 8'h80, 1'b0});
    qb.push_back('{3'd0, 8'hD2, 8'h80, 1'b1});
    wr_b(2, 8'hC1, 8'h82, 1'b0);
    wr_b(2, 8'hC2, 8'h82, 1'b0);
    wr_b(0, 8'hD1, 8'h80, 1'b0);
    wr_b(0, 8'hD2, 8'h80, 1'b1);
    @(negedge clk);
    chk("t2_gap", {ifb.merged_upload_req, ifb.merged_upload_valid, ifb.merged_upload_chan},
        {1'b1, 1'b0, 3'd2});
    tick();
    wr_b(2, 8'hC3, 8'h82, 1'b1);
    drain(1);

    // 4: stall 10 clks mid-packet on src3, register held on the second byte
    qa.push_back('{3'd3, 8'hB1, 8'h53, 1'b0});
    qa.push_back('{3'd3, 8'hB2, 8'h53, 1'b0});
    qa.push_back('{3'd3, 8'hB3, 8'h53, 1'b1});
    wr_a(3, 8'hB1, 8'h53, 1'b0);
    wr_a(3, 8'hB2, 8'h53, 1'b0);
    wr_a(3, 8'hB3, 8'h53, 1'b1);
    ifa.processor_upload_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold", {ifa.merged_upload_valid, ifa.merged_upload_data,
                      ifa.merged_upload_source, ifa.merged_upload_last},
          {1'b1, 8'hB2, 8'h53, 1'b0});
      tick();
    end
    ifa.processor_upload_ready = 1'b1;
    drain(0);

    // 3: round-robin over two one-byte packets per source
    ifa.processor_upload_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        qa.push_back('{3'(s), 8'(8'h30 + r*4 + s), 8'(8'h60 + s), 1'b1});
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        wr_a(s, 8'(8'h30 + r*4 + s), 8'(8'h60 + s), 1'b1);
    ifa.processor_upload_ready = 1'b1;
    drain(0);

    // 5: src0 fills while locked on a stalled src1 packet
    ifa.processor_upload_ready = 1'b0;
    qa.push_back('{3'd1, 8'hE1, 8'h71, 1'b0});
    qa.push_back('{3'd1, 8'hE2, 8'h71, 1'b1});
    for (int i = 0; i < 4; i++)
      qa.push_back('{3'd0, 8'(8'hF1 + i), 8'h70, (i == 3)});
    wr_a(1, 8'hE1, 8'h71, 1'b0);
    for (int i = 0; i < 3; i++) wr_a(0, 8'(8'hF1 + i), 8'h70, 1'b0);
    chk("t5_rdy3", ifa.src_upload_ready[0], 1'b1);
    wr_a(0, 8'hF4, 8'h70, 1'b1);
    chk("t5_full", {ifa.src_upload_ready[0], ifa.src_overflow}, {1'b0, 4'b0000});
    wr_a(0, 8'hF5, 8'h70, 1'b0);
    wr_a(0, 8'hF6, 8'h70, 1'b1);
    chk("t5_ovf", {ifa.src_upload_ready[0], ifa.src_overflow}, {1'b0, 4'b0001});
    wr_a(1, 8'hE2, 8'h71, 1'b1);
    ifa.processor_upload_ready = 1'b1;
    drain(0);
    chk("t5_sticky", {ifa.src_upload_ready[0], ifa.src_overflow}, {1'b1, 4'b0001});

    // 6: reset during STREAM aborts the packet and empties the FIFOs
    ifa.processor_upload_ready = 1'b0;
    wr_a(2, 8'h11, 8'h92, 1'b0);
    wr_a(2, 8'h12, 8'h92, 1'b0);
    wr_a(3, 8'h13, 8'h93, 1'b1);
    @(negedge clk);
    chk("t6_stream", {ifa.merged_upload_req, ifa.merged_upload_valid, ifa.merged_upload_chan},
        {1'b1, 1'b1, 3'd2});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_a("t6rst");
    tick();
    ifa.processor_upload_ready = 1'b1;
    repeat (5) tick();
    qa.push_back('{3'd1, 8'h21, 8'h91, 1'b1});
    wr_a(1, 8'h21, 8'h91, 1'b1);
    drain(0);
    chk("t6_after", {ifa.merged_upload_req, ifa.merged_upload_valid}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
